// File: rtl/osc_freq_counter.sv
// osc_freq_counter
//   Digital frequency detector. Rising edges of an asynchronous oscillator
//   input are counted over a gate window of G clk cycles. The edge count of
//   each completed window is reported, and the counter saturates rather than
//   wrapping.
//
//   Optional feature: define LOCK_DETECT_EN to build the frequency-lock
//   detector (target/tol compare plus consecutive-window match counter).
//   Without it, lock is tied low and target/tol are ignored.
//
// Parameters
//   CNT_W        edge-count width
//   GATE_W       gate-window length width (clk cycles)
//   SYNC_STAGES  synchronizer depth on osc_in (>= 2)
//   LOCK_WINS    consecutive in-range windows needed for lock
//
// Ports
//   clk          in   system/reference clock, posedge
//   rst          in   synchronous active-high reset
//   osc_in       in   asynchronous oscillator input
//   start        in   begin measurement (sampled only when idle)
//   continuous   in   re-arm after each window (sampled at window end)
//   gate_cycles  in   window length G, latched on accepted start, 0 -> 1
//   target       in   expected count for the lock compare
//   tol          in   allowed |count - target|
//   busy         out  measurement in progress
//   count        out  edge count of the last completed window
//   count_valid  out  one-cycle pulse when count updates
//   overflow     out  last window saturated the count
//   lock         out  frequency-lock indicator
module osc_freq_counter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_WINS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_in,
  input  logic              start,
  input  logic              continuous,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic [CNT_W-1:0]  target,
  input  logic [CNT_W-1:0]  tol,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              count_valid,
  output logic              overflow,
  output logic              lock
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;

  state_t                  r_state, w_state_next;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    r_sync_prev;
  logic [GATE_W-1:0]       r_gate_len, r_gate_cnt;
  logic [CNT_W-1:0]        r_edge_cnt, r_count;
  logic                    r_ovf, r_overflow, r_count_valid;
  logic                    w_edge, w_last, w_ovf_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [CNT_W:0]          w_sum;

  // Saturating increment: returns {saturated_this_step, new_value}.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (!inc)
      return {1'b0, v};
    else if (&v)
      return {1'b1, v};
    else
      return {1'b0, v + 1'b1};
  endfunction

  assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
  // Last gate cycle: the result registered now includes this cycle's edge,
  // so count and count_valid appear together in the DONE cycle.
  assign w_last     = (r_state == S_COUNT) && (r_gate_cnt == GATE_W'(1));
  assign w_sum      = sat_inc(r_edge_cnt, w_edge);
  assign w_cnt_next = w_sum[CNT_W-1:0];
  assign w_ovf_next = r_ovf | w_sum[CNT_W];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_ARM;
      S_ARM:   w_state_next = S_COUNT;
      S_COUNT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = continuous ? S_ARM : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sync        <= '0;
      r_sync_prev   <= 1'b0;
      r_gate_len    <= '0;
      r_gate_cnt    <= '0;
      r_edge_cnt    <= '0;
      r_ovf         <= 1'b0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_count_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      // Synchronizer stage boundary: osc_in -> r_sync -> r_sync_prev
      r_sync        <= {r_sync[SYNC_STAGES-2:0], osc_in};
      r_sync_prev   <= r_sync[SYNC_STAGES-1];
      r_count_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start)
            r_gate_len <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
        end
        S_ARM: begin
          r_gate_cnt <= r_gate_len;
          r_edge_cnt <= '0;
          r_ovf      <= 1'b0;
        end
        S_COUNT: begin
          r_gate_cnt <= r_gate_cnt - 1'b1;
          r_edge_cnt <= w_cnt_next;
          r_ovf      <= w_ovf_next;
          if (w_last) begin
            r_count       <= w_cnt_next;
            r_overflow    <= w_ovf_next;
            r_count_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign count       = r_count;
  assign count_valid = r_count_valid;
  assign overflow    = r_overflow;

`ifdef LOCK_DETECT_EN
  localparam int MATCH_W = $clog2(LOCK_WINS + 1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_WINS);

  logic [MATCH_W-1:0]    r_match, w_match_next;
  logic                  r_lock, w_in_range;
  logic signed [CNT_W:0] w_diff;
  logic [CNT_W:0]        w_absdiff;

  // The difference of two unsigned CNT_W values never reaches the most
  // negative CNT_W+1 value, so negation cannot overflow.
  function automatic logic [CNT_W:0] abs_diff(input logic signed [CNT_W:0] d);
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  always_comb begin
    w_diff     = $signed({1'b0, w_cnt_next}) - $signed({1'b0, target});
    w_absdiff  = abs_diff(w_diff);
    w_in_range = (w_absdiff <= {1'b0, tol}) && !w_ovf_next;
    if (!w_in_range)
      w_match_next = '0;
    else if (r_match == MATCH_MAX)
      w_match_next = r_match;
    else
      w_match_next = r_match + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_match <= '0;
      r_lock  <= 1'b0;
    end else if (w_last) begin
      r_match <= w_match_next;
      r_lock  <= (w_match_next == MATCH_MAX);
    end
  end

  assign lock = r_lock;
`else
  logic w_unused_lock_inputs;
  assign w_unused_lock_inputs = ^{target, tol};
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_osc_freq_counter.sv
`timescale 1ns/1ps
module tb_osc_freq_counter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, osc, start, continuous, start6;
  logic [15:0] gate_cycles, target, tol, gate6;
  logic [5:0]  target6, tol6;
  logic        busy, count_valid, overflow, lock;
  logic [15:0] count;
  logic        busy6, count_valid6, overflow6, lock6;
  logic [5:0]  count6;

  int checks = 0;
  int errors = 0;
  int osc_half = 4;   // osc half-period in clk cycles, 0 = held low

  osc_freq_counter dut (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start), .continuous(continuous),
    .gate_cycles(gate_cycles), .target(target), .tol(tol),
    .busy(busy), .count(count), .count_valid(count_valid),
    .overflow(overflow), .lock(lock)
  );

  osc_freq_counter #(.CNT_W(6)) dut6 (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start6), .continuous(1'b0),
    .gate_cycles(gate6), .target(target6), .tol(tol6),
    .busy(busy6), .count(count6), .count_valid(count_valid6),
    .overflow(overflow6), .lock(lock6)
  );

  // Oscillator transitions land 2 ns before a clk posedge, never on it.
  initial begin
    osc = 1'b0;
    #3;
    forever begin
      if (osc_half == 0) begin
        osc = 1'b0;
        #10;
      end else begin
        #(osc_half * 10);
        osc = ~osc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick(1);
      if (count_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  int pulses;
  int pc[4];
  bit seen, got;

  initial begin
    rst = 1'b1; start = 1'b0; start6 = 1'b0; continuous = 1'b0;
    gate_cycles = 16'd80; target = 16'd0; tol = 16'd0;
    gate6 = 16'd400; target6 = 6'd0; tol6 = 6'd0;
    #1;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_valid", count_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_lock", lock, 0);
    rst = 1'b0;
    tick(20);

    // Period 8, G=80; start and gate_cycles poked mid-window are ignored
    start = 1'b1; tick(1); start = 1'b0;
    tick(40);
    start = 1'b1; gate_cycles = 16'd5; tick(1); start = 1'b0;
    tick(39);
    check("p8_valid_t81", count_valid, 0);
    tick(1);
    check("p8_valid_t82", count_valid, 1);
    check("p8_count", count, 10);
    check("p8_overflow", overflow, 0);
    check("p8_busy_t82", busy, 1);
    check("p8_lock_off", lock, 0);
    tick(1);
    check("p8_busy_t83", busy, 0);
    check("p8_valid_t83", count_valid, 0);
    check("p8_count_held", count, 10);

    // Oscillator held low, G=100
    osc_half = 0;
    tick(20);
    gate_cycles = 16'd100;
    start = 1'b1; tick(1); start = 1'b0;
    tick(101);
    check("hold0_valid", count_valid, 1);
    check("hold0_count", count, 0);
    check("hold0_overflow", overflow, 0);

    // gate_cycles = 0 behaves as a 1-cycle window
    osc_half = 4;
    tick(30);
    gate_cycles = 16'd0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(1);
    check("g0_valid_t2", count_valid, 0);
    tick(1);
    check("g0_valid_t3", count_valid, 1);
    check("g0_count_le1", (count <= 16'd1), 1);
    tick(2);
    check("g0_busy", busy, 0);

    // Continuous, G=40, drop continuous after the 2nd pulse
    gate_cycles = 16'd40;
    continuous = 1'b1;
    start = 1'b1; tick(1); start = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 300; n++) begin
      tick(1);
      if (pulses >= 2) continuous = 1'b0;
      if (count_valid) begin
        if (pulses < 4) pc[pulses] = n;
        pulses++;
        check("cont_count", count, 5);
      end
    end
    check("cont_pulses", pulses, 3);
    check("cont_first", pc[0], 41);
    check("cont_gap1", pc[1] - pc[0], 42);
    check("cont_gap2", pc[2] - pc[1], 42);
    check("cont_idle", busy, 0);

    // Reset in the middle of a window
    gate_cycles = 16'd80;
    start = 1'b1; tick(1); start = 1'b0;
    tick(20);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rstmid_count", count, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", count_valid, 0);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick(1);
      if (count_valid) seen = 1'b1;
    end
    check("rstmid_no_valid", seen, 0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(81);
    check("rstmid_restart_valid", count_valid, 1);
    check("rstmid_restart_count", count, 10);

    // 6-bit counter saturates: period 4, G=400 -> 100 edges
    osc_half = 2;
    tick(30);
    start6 = 1'b1; tick(1); start6 = 1'b0;
    tick(400);
    check("sat_valid_early", count_valid6, 0);
    tick(1);
    check("sat_valid", count_valid6, 1);
    check("sat_count", count6, 63);
    check("sat_overflow", overflow6, 1);
    check("sat_lock", lock6, 0);

`ifdef LOCK_DETECT_EN
    // Lock after 4 in-range windows, lost when frequency doubles
    rst = 1'b1; tick(2); rst = 1'b0;
    osc_half = 4;
    tick(30);
    target = 16'd10; tol = 16'd1; gate_cycles = 16'd80; continuous = 1'b1;
    start = 1'b1; tick(1); start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wait_valid(100, got);
      check("lock_pulse", got, 1);
      check("lock_count", count, 10);
      check("lock_state", lock, (k == 4) ? 1 : 0);
    end
    osc_half = 2;
    wait_valid(100, got);
    check("unlock_pulse1", got, 1);
    wait_valid(100, got);
    check("unlock_pulse2", got, 1);
    check("unlock_count", count, 20);
    check("unlock_lock", lock, 0);
    continuous = 1'b0;
    wait_valid(100, got);
    check("unlock_last_pulse", got, 1);
    tick(2);
    check("unlock_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
